// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path and the command display.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 10416;
    localparam int DEFAULT_HOLD_CLKS    = 100000000;

    // Drive command bytes understood by the 7-segment display
    localparam logic [7:0] CMD_GAS         = 8'h74;
    localparam logic [7:0] CMD_BRAKE       = 8'h76;
    localparam logic [7:0] CMD_LEFT        = 8'h77;
    localparam logic [7:0] CMD_RIGHT       = 8'h75;
    localparam logic [7:0] CMD_GAS_LEFT    = 8'h71;
    localparam logic [7:0] CMD_GAS_RIGHT   = 8'h70;
    localparam logic [7:0] CMD_BRAKE_LEFT  = 8'h73;
    localparam logic [7:0] CMD_BRAKE_RIGHT = 8'h72;

endpackage

// File: rtl/uart_rx_stretch_pulse_stretcher.sv
// Retriggerable hold counter: active stays high for HOLD_CLKS cycles after the last trig.
module pulse_stretcher
    import uart_pkg::*;
#(
    parameter int HOLD_CLKS = DEFAULT_HOLD_CLKS
) (
    input  logic clk,
    input  logic reset,
    input  logic trig,
    output logic active
);

    localparam int HW = $clog2(HOLD_CLKS + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CLKS);

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (trig) begin
            hold_cnt_d = HOLD_LOAD;
        end else if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign active = (hold_cnt_q != '0);

endmodule

// File: rtl/uart_rx_stretch.sv
// 8N1 UART receiver with a stretched receive window for the command display.
// Define UART_PARITY_EN to expect an even-parity bit after data bit 7.
module uart_rx_stretch
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int HOLD_CLKS    = DEFAULT_HOLD_CLKS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx,
    output logic [7:0] Rx_Data,
    output logic       rx_done,
    output logic       receive_pulse,
    output logic       framing_err,
    output logic       parity_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          rx_s;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_done_q, rx_done_d;
    logic          framing_err_q, framing_err_d;
    logic          parity_ok;

`ifdef UART_PARITY_EN
    logic par_bit_q, par_bit_d;
    logic parity_err_q, parity_err_d;

    assign parity_ok = (par_bit_q == ^shreg_q);
`else
    assign parity_ok = 1'b1;
`endif

    assign rx_s = sync2_q;

    always_comb begin
        sync1_d       = Rx;
        sync2_d       = sync1_q;
        state_d       = state_q;
        cnt_d         = cnt_q + CW'(1);
        idx_d         = idx_q;
        shreg_d       = shreg_q;
        rx_data_d     = rx_data_q;
        rx_done_d     = 1'b0;
        framing_err_d = 1'b0;
`ifdef UART_PARITY_EN
        par_bit_d     = par_bit_q;
        parity_err_d  = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            // Re-check the start bit mid-way so short glitches are rejected
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    par_bit_d = rx_s;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                        if (parity_ok) begin
                            rx_data_d = shreg_q;
                            rx_done_d = 1'b1;
                        end
`ifdef UART_PARITY_EN
                        else begin
                            parity_err_d = 1'b1;
                        end
`endif
                    end else begin
                        framing_err_d = 1'b1;
                        state_d       = BREAK;
                    end
                end
            end
            // A held-low line must return high before another start bit counts
            BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            shreg_q       <= '0;
            rx_data_q     <= '0;
            rx_done_q     <= 1'b0;
            framing_err_q <= 1'b0;
`ifdef UART_PARITY_EN
            par_bit_q     <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shreg_q       <= shreg_d;
            rx_data_q     <= rx_data_d;
            rx_done_q     <= rx_done_d;
            framing_err_q <= framing_err_d;
`ifdef UART_PARITY_EN
            par_bit_q     <= par_bit_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    // Loading on the pre-strobe event makes the window rise together with rx_done
    pulse_stretcher #(
        .HOLD_CLKS(HOLD_CLKS)
    ) u_stretch (
        .clk   (clk),
        .reset (reset),
        .trig  (rx_done_d),
        .active(receive_pulse)
    );

    assign Rx_Data     = rx_data_q;
    assign rx_done     = rx_done_q;
    assign framing_err = framing_err_q;
`ifdef UART_PARITY_EN
    assign parity_err  = parity_err_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_stretch.sv
// Self-checking bench for uart_rx_stretch; honours UART_PARITY_EN for the frame format.
`timescale 1ns/1ps
module tb_uart_rx_stretch;

    localparam int CPB       = 16;
    localparam int HOLD      = 64;
    localparam int LONG_HOLD = 256;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       Rx;
    logic [7:0] Rx_Data;
    logic       rx_done, receive_pulse, framing_err, parity_err;
    logic [7:0] long_data;
    logic       long_done, long_pulse, long_ferr, long_perr;

    uart_rx_stretch #(.CLKS_PER_BIT(CPB), .HOLD_CLKS(HOLD)) dut (
        .clk          (clk),
        .reset        (reset),
        .Rx           (Rx),
        .Rx_Data      (Rx_Data),
        .rx_done      (rx_done),
        .receive_pulse(receive_pulse),
        .framing_err  (framing_err),
        .parity_err   (parity_err)
    );

    uart_rx_stretch #(.CLKS_PER_BIT(CPB), .HOLD_CLKS(LONG_HOLD)) dut_long (
        .clk          (clk),
        .reset        (reset),
        .Rx           (Rx),
        .Rx_Data      (long_data),
        .rx_done      (long_done),
        .receive_pulse(long_pulse),
        .framing_err  (long_ferr),
        .parity_err   (long_perr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];
    int exp_done_total = 0, exp_ferr_total = 0, exp_perr_total = 0;

    int cycle = 0;
    int done_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
    int pulse_cycles = 0, pulse_falls = 0, pulse_len = 0, last_pulse_len = 0;
    int last_done_cycle = 0, prev_done_cycle = 0, last_fall_cycle = 0;
    logic pulse_prev = 1'b0;
    int long_done_cnt = 0, long_ferr_cnt = 0, long_perr_cnt = 0;
    int long_falls = 0, long_fall_cycle = 0;
    logic long_prev = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       bad_par;
        int         exp_done;
        int         exp_ferr;
        int         exp_perr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 'h%0h, required 'h%0h", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input logic bad_parity);
        logic [10:0] frame;
        logic        good;
        frame = {stop_bit, (^data) ^ bad_parity, data, 1'b0};
`ifdef UART_PARITY_EN
        good = stop_bit && !bad_parity;
        if (stop_bit && bad_parity) exp_perr_total++;
`else
        good = stop_bit;
`endif
        if (!stop_bit) exp_ferr_total++;
        if (good) begin
            exp_q.push_back(data);
            exp_done_total++;
        end
        for (int i = 0; i < FRAME_BITS; i++) begin
            Rx = (i == FRAME_BITS - 1) ? frame[10] : frame[i];
            waitCycles(CPB);
        end
    endtask

    always @(negedge clk) begin
        cycle++;
        if (rx_done === 1'b1) begin
            done_cnt++;
            prev_done_cycle = last_done_cycle;
            last_done_cycle = cycle;
            checkOutput("pulse_rises_with_done", {31'd0, receive_pulse}, 32'd1);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_rx_done: got Rx_Data 'h%0h, required no strobe", Rx_Data);
            end else begin
                checkOutput("scoreboard_rx_data", {24'd0, Rx_Data}, {24'd0, exp_q.pop_front()});
            end
        end
        if (framing_err === 1'b1) ferr_cnt++;
        if (parity_err === 1'b1) perr_cnt++;
        if (receive_pulse === 1'b1) begin
            pulse_cycles++;
            pulse_len++;
        end else if (pulse_prev) begin
            pulse_falls++;
            last_pulse_len  = pulse_len;
            last_fall_cycle = cycle;
            pulse_len       = 0;
        end
        pulse_prev = (receive_pulse === 1'b1);
        if (long_done === 1'b1) long_done_cnt++;
        if (long_ferr === 1'b1) long_ferr_cnt++;
        if (long_perr === 1'b1) long_perr_cnt++;
        if (long_pulse !== 1'b1 && long_prev) begin
            long_falls++;
            long_fall_cycle = cycle;
        end
        long_prev = (long_pulse === 1'b1);
    end

    initial begin
        int d0, f0, p0, pc0, pf0, lf0;

        vecs[0] = '{8'h74, 1'b1, 1'b0, 1, 0, 0, 8'h74};
        vecs[1] = '{8'h70, 1'b1, 1'b0, 1, 0, 0, 8'h70};
        vecs[2] = '{8'h77, 1'b0, 1'b0, 0, 1, 0, 8'h70};
        vecs[3] = '{8'h72, 1'b1, 1'b0, 1, 0, 0, 8'h72};
        vecs[4] = '{8'h75, 1'b1, 1'b0, 1, 0, 0, 8'h75};
`ifdef UART_PARITY_EN
        vecs[5] = '{8'h71, 1'b1, 1'b1, 0, 0, 1, 8'h75};
        vecs[6] = '{8'h73, 1'b0, 1'b1, 0, 1, 0, 8'h75};
`else
        vecs[5] = '{8'h71, 1'b1, 1'b1, 1, 0, 0, 8'h71};
        vecs[6] = '{8'h73, 1'b0, 1'b1, 0, 1, 0, 8'h71};
`endif

        reset = 1'b1;
        Rx    = 1'b1;
        waitCycles(3);
        @(negedge clk);
        checkOutput("reset_rx_data", {24'd0, Rx_Data}, 32'h00);
        checkOutput("reset_rx_done", {31'd0, rx_done}, 32'd0);
        checkOutput("reset_pulse", {31'd0, receive_pulse}, 32'd0);
        checkOutput("reset_framing_err", {31'd0, framing_err}, 32'd0);
        checkOutput("reset_parity_err", {31'd0, parity_err}, 32'd0);
        waitCycles(1);
        reset = 1'b0;
        waitCycles(5);

        for (int v = 0; v < 7; v++) begin
            d0 = done_cnt;
            f0 = ferr_cnt;
            p0 = perr_cnt;
            applyStimulus(vecs[v].data, vecs[v].stop_bit, vecs[v].bad_par);
            Rx = 1'b1;
            waitCycles(24);
            checkOutput($sformatf("vec%0d_done", v), done_cnt - d0, vecs[v].exp_done);
            checkOutput($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
            checkOutput($sformatf("vec%0d_perr", v), perr_cnt - p0, vecs[v].exp_perr);
            checkOutput($sformatf("vec%0d_data", v), {24'd0, Rx_Data}, {24'd0, vecs[v].exp_data});
        end
        waitCycles(100);

        pf0 = pulse_falls;
        applyStimulus(8'h74, 1'b1, 1'b0);
        Rx = 1'b1;
        waitCycles(100);
        checkOutput("width_falls", pulse_falls - pf0, 32'd1);
        checkOutput("width_len", last_pulse_len, HOLD);
        checkOutput("width_fall_delay", last_fall_cycle - last_done_cycle, HOLD);
        checkOutput("width_data", {24'd0, Rx_Data}, 32'h74);

        d0 = done_cnt;
        f0 = ferr_cnt;
        p0 = perr_cnt;
        Rx = 1'b0;
        waitCycles(4);
        Rx = 1'b1;
        waitCycles(40);
        checkOutput("glitch_done", done_cnt - d0, 32'd0);
        checkOutput("glitch_ferr", ferr_cnt - f0, 32'd0);
        checkOutput("glitch_perr", perr_cnt - p0, 32'd0);
        checkOutput("glitch_data", {24'd0, Rx_Data}, 32'h74);

        d0  = done_cnt;
        f0  = ferr_cnt;
        pc0 = pulse_cycles;
        applyStimulus(8'h77, 1'b0, 1'b0);
        Rx = 1'b0;
        waitCycles(40);
        Rx = 1'b1;
        waitCycles(20);
        checkOutput("break_ferr_once", ferr_cnt - f0, 32'd1);
        checkOutput("break_no_done", done_cnt - d0, 32'd0);
        checkOutput("break_data_kept", {24'd0, Rx_Data}, 32'h74);
        checkOutput("break_no_retrigger", pulse_cycles - pc0, 32'd0);
        d0 = done_cnt;
        applyStimulus(8'h75, 1'b1, 1'b0);
        Rx = 1'b1;
        waitCycles(24);
        checkOutput("after_break_done", done_cnt - d0, 32'd1);
        checkOutput("after_break_data", {24'd0, Rx_Data}, 32'h75);
        waitCycles(300);

        d0  = done_cnt;
        pf0 = pulse_falls;
        lf0 = long_falls;
        applyStimulus(8'h71, 1'b1, 1'b0);
        applyStimulus(8'h72, 1'b1, 1'b0);
        Rx = 1'b1;
        waitCycles(300);
        checkOutput("b2b_done", done_cnt - d0, 32'd2);
        checkOutput("b2b_spacing", last_done_cycle - prev_done_cycle, FRAME_BITS * CPB);
        checkOutput("b2b_data", {24'd0, Rx_Data}, 32'h72);
        checkOutput("b2b_short_falls", pulse_falls - pf0, 32'd2);
        checkOutput("b2b_short_fall_delay", last_fall_cycle - last_done_cycle, HOLD);
        checkOutput("b2b_long_falls", long_falls - lf0, 32'd1);
        checkOutput("b2b_long_fall_delay", long_fall_cycle - last_done_cycle, LONG_HOLD);

        d0 = done_cnt;
        f0 = ferr_cnt;
        p0 = perr_cnt;
        begin
            logic [7:0] partial;
            partial = 8'h73;
            Rx = 1'b0;
            waitCycles(CPB);
            for (int i = 0; i < 4; i++) begin
                Rx = partial[i];
                waitCycles(CPB);
            end
        end
        reset = 1'b1;
        waitCycles(1);
        reset = 1'b0;
        Rx    = 1'b1;
        @(negedge clk);
        checkOutput("midreset_data", {24'd0, Rx_Data}, 32'h00);
        checkOutput("midreset_done", {31'd0, rx_done}, 32'd0);
        checkOutput("midreset_pulse", {31'd0, receive_pulse}, 32'd0);
        checkOutput("midreset_ferr", {31'd0, framing_err}, 32'd0);
        waitCycles(200);
        checkOutput("midreset_no_strobes", (done_cnt - d0) + (ferr_cnt - f0) + (perr_cnt - p0), 32'd0);
        d0 = done_cnt;
        applyStimulus(8'h76, 1'b1, 1'b0);
        Rx = 1'b1;
        waitCycles(24);
        checkOutput("post_reset_done", done_cnt - d0, 32'd1);
        checkOutput("post_reset_data", {24'd0, Rx_Data}, 32'h76);

`ifdef UART_PARITY_EN
        d0 = done_cnt;
        p0 = perr_cnt;
        applyStimulus(8'h73, 1'b1, 1'b1);
        Rx = 1'b1;
        waitCycles(24);
        checkOutput("parity_bad_perr", perr_cnt - p0, 32'd1);
        checkOutput("parity_bad_no_done", done_cnt - d0, 32'd0);
        checkOutput("parity_bad_data", {24'd0, Rx_Data}, 32'h76);
        d0 = done_cnt;
        applyStimulus(8'h73, 1'b1, 1'b0);
        Rx = 1'b1;
        waitCycles(24);
        checkOutput("parity_good_done", done_cnt - d0, 32'd1);
        checkOutput("parity_good_data", {24'd0, Rx_Data}, 32'h73);
        checkOutput("long_final_data", {24'd0, long_data}, 32'h73);
`else
        checkOutput("long_final_data", {24'd0, long_data}, 32'h76);
`endif
        waitCycles(10);

        checkOutput("total_done", done_cnt, exp_done_total);
        checkOutput("total_ferr", ferr_cnt, exp_ferr_total);
        checkOutput("total_perr", perr_cnt, exp_perr_total);
        checkOutput("long_total_done", long_done_cnt, exp_done_total);
        checkOutput("long_total_ferr", long_ferr_cnt, exp_ferr_total);
        checkOutput("long_total_perr", long_perr_cnt, exp_perr_total);
        checkOutput("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
